// File: rtl/shift_tx_ctrl.sv
// Serial-transmit controller driving an 8-bit bidirectional shift register:
// loads a byte, then shifts it out as a start / 8 data / stop bit frame on txd.
module shift_tx_ctrl #(
   parameter int unsigned BIT_CYCLES = 4,
   parameter bit          MSB_FIRST  = 1'b0
) (
   input  logic       c,
   input  logic       rst,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   input  logic [7:0] q,
   output logic [7:0] sr_d,
   output logic       sr_l,
   output logic       sr_r,
   output logic       sr_i,
   output logic       txd,
   output logic       busy,
   output logic       done
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_DATA  = 2'd2,
      S_STOP  = 2'd3
   } state_t;

   localparam logic [7:0] LP_CNT_LAST = 8'(BIT_CYCLES - 1);

   state_t     r_state;
   state_t     w_state_nxt;
   logic [7:0] r_cnt;
   logic [7:0] w_cnt_nxt;
   logic [2:0] r_bit;
   logic [2:0] w_bit_nxt;
   logic       r_done;
   logic       w_done_nxt;
   logic       w_bit_end;
   logic       w_accept;
   logic       w_shift_l;
   logic       w_shift_r;

   assign w_bit_end = (r_cnt == LP_CNT_LAST);
   assign w_accept  = (r_state == S_IDLE) && tx_valid && !rst;

   // LSB-first drains toward bit 0 (l=1,r=0); MSB-first drains toward bit 7 (l=0,r=1).
   assign w_shift_l = !MSB_FIRST;
   assign w_shift_r = MSB_FIRST;

   // NOTE: state registers use non-blocking assignments so every flop samples
   // pre-edge values; mixing in blocking assignments creates simulation races.
   always_ff @(posedge c) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_cnt   <= 8'd0;
         r_bit   <= 3'd0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_bit   <= w_bit_nxt;
         r_done  <= w_done_nxt;
      end
   end

   // NOTE: every signal driven here gets a default first, otherwise a path
   // that skips an assignment would infer a latch.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_bit_nxt   = r_bit;
      w_done_nxt  = 1'b0;
      txd         = 1'b1;
      sr_l        = 1'b0;
      sr_r        = 1'b0;
      tx_ready    = 1'b0;

      case (r_state)
         S_IDLE: begin
            tx_ready  = !rst;
            w_cnt_nxt = 8'd0;
            w_bit_nxt = 3'd0;
            if (w_accept) begin
               sr_l        = 1'b1;
               sr_r        = 1'b1;
               w_state_nxt = S_START;
            end
         end

         S_START: begin
            txd = 1'b0;
            if (w_bit_end) begin
               w_cnt_nxt   = 8'd0;
               w_state_nxt = S_DATA;
            end else begin
               w_cnt_nxt = r_cnt + 8'd1;
            end
         end

         S_DATA: begin
            txd = MSB_FIRST ? q[7] : q[0];
            if (w_bit_end) begin
               w_cnt_nxt = 8'd0;
               sr_l      = w_shift_l && !rst;
               sr_r      = w_shift_r && !rst;
               if (r_bit == 3'd7) begin
                  w_bit_nxt   = 3'd0;
                  w_state_nxt = S_STOP;
               end else begin
                  w_bit_nxt = r_bit + 3'd1;
               end
            end else begin
               w_cnt_nxt = r_cnt + 8'd1;
            end
         end

         S_STOP: begin
            txd = 1'b1;
            if (w_bit_end) begin
               w_cnt_nxt   = 8'd0;
               w_done_nxt  = 1'b1;
               w_state_nxt = S_IDLE;
            end else begin
               w_cnt_nxt = r_cnt + 8'd1;
            end
         end

         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   assign sr_d = tx_data;
   assign sr_i = 1'b1;
   assign busy = (r_state != S_IDLE);
   assign done = r_done;

endmodule

// File: tb/tb_shift_tx_ctrl.sv
// Directed bench for shift_tx_ctrl: two instances (LSB-first/2 cycles and
// MSB-first/1 cycle), each with a behavioural shift register on its outputs.
module tb_shift_tx_ctrl;

   logic       clk;
   logic       rst;

   logic [7:0] a_data, a_q, a_sr_d;
   logic       a_valid, a_ready, a_l, a_r, a_i, a_txd, a_busy, a_done;
   logic [7:0] b_data, b_q, b_sr_d;
   logic       b_valid, b_ready, b_l, b_r, b_i, b_txd, b_busy, b_done;

   int checks = 0;
   int errors = 0;

   shift_tx_ctrl #(.BIT_CYCLES(2), .MSB_FIRST(1'b0)) u_lsb (
      .c(clk), .rst(rst), .tx_data(a_data), .tx_valid(a_valid), .tx_ready(a_ready),
      .q(a_q), .sr_d(a_sr_d), .sr_l(a_l), .sr_r(a_r), .sr_i(a_i),
      .txd(a_txd), .busy(a_busy), .done(a_done)
   );

   shift_tx_ctrl #(.BIT_CYCLES(1), .MSB_FIRST(1'b1)) u_msb (
      .c(clk), .rst(rst), .tx_data(b_data), .tx_valid(b_valid), .tx_ready(b_ready),
      .q(b_q), .sr_d(b_sr_d), .sr_l(b_l), .sr_r(b_r), .sr_i(b_i),
      .txd(b_txd), .busy(b_busy), .done(b_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural model of the 8-bit bidirectional shift register.
   initial begin
      a_q = 8'h00;
      b_q = 8'h00;
   end

   always @(posedge clk) begin
      case ({a_l, a_r})
         2'b11:   a_q <= a_sr_d;
         2'b10:   a_q <= {a_i, a_q[7:1]};
         2'b01:   a_q <= {a_q[6:0], a_i};
         default: a_q <= a_q;
      endcase
      case ({b_l, b_r})
         2'b11:   b_q <= b_sr_d;
         2'b10:   b_q <= {b_i, b_q[7:1]};
         2'b01:   b_q <= {b_q[6:0], b_i};
         default: b_q <= b_q;
      endcase
   end

   // Frame bit j (0 = start, 1..8 = data, 9 = stop) of byte d.
   function automatic logic frame_bit(input logic [7:0] d, input bit msb, input int j);
      if (j == 0) return 1'b0;
      if (j >= 9) return 1'b1;
      return msb ? d[8-j] : d[j-1];
   endfunction

   task automatic test_reset();
      rst     = 1'b1;
      a_valid = 1'b0;
      a_data  = 8'h00;
      b_valid = 1'b0;
      b_data  = 8'h00;
      @(negedge clk); #1;
      checks++;
      if (a_ready !== 1'b0) begin errors++; $display("FAIL reset_ready_in_rst: got %b want 0", a_ready); end
      @(negedge clk);
      rst = 1'b0;
      #1;
      checks++;
      if ({a_txd, a_busy, a_ready, a_l, a_r, a_done} !== 6'b101000) begin
         errors++;
         $display("FAIL reset_outputs: txd/busy/ready/l/r/done got %b want 101000",
                  {a_txd, a_busy, a_ready, a_l, a_r, a_done});
      end
      checks++;
      if ({a_i, a_sr_d} !== 9'h100) begin errors++; $display("FAIL reset_sr_i_d: got %h want 100", {a_i, a_sr_d}); end
      checks++;
      if ({b_txd, b_busy, b_ready, b_done} !== 4'b1010) begin
         errors++; $display("FAIL reset_msb_outputs: got %b want 1010", {b_txd, b_busy, b_ready, b_done});
      end
   endtask

   task automatic test_lsb_send();
      int exp_txd [20] = '{0,0, 1,1,0,0,1,1,0,0,0,0,1,1,0,0,1,1, 1,1};
      int shifts = 0;
      int txd_err = 0;
      int bad = 0;
      @(negedge clk);
      a_data  = 8'hA5;
      a_valid = 1'b1;
      #1;
      checks++;
      if ({a_ready, a_l, a_r, a_sr_d} !== {3'b111, 8'hA5}) begin
         errors++; $display("FAIL lsb_accept: ready/l/r/d got %h want 7a5", {a_ready, a_l, a_r, a_sr_d});
      end
      for (int cyc = 1; cyc <= 20; cyc++) begin
         @(negedge clk);
         a_valid = 1'b0;
         #1;
         if (a_txd !== 1'(exp_txd[cyc-1])) begin
            txd_err++;
            $display("FAIL lsb_txd cycle %0d: got %b want %0d", cyc, a_txd, exp_txd[cyc-1]);
         end
         if (a_done !== 1'b0 || a_busy !== 1'b1) bad++;
         if (a_l && !a_r) shifts++;
         if (a_r) bad++;
      end
      checks++;
      if (txd_err != 0) errors++;
      checks++;
      if (bad != 0) begin errors++; $display("FAIL lsb_busy_mode: got %0d bad cycles want 0", bad); end
      @(negedge clk); #1;
      checks++;
      if ({a_done, a_busy} !== 2'b10) begin errors++; $display("FAIL lsb_done: done/busy got %b want 10", {a_done, a_busy}); end
      checks++;
      if (a_q !== 8'hFF) begin errors++; $display("FAIL lsb_q_end: got %h want ff", a_q); end
      checks++;
      if (shifts != 8) begin errors++; $display("FAIL lsb_shift_count: got %0d want 8", shifts); end
      @(negedge clk); #1;
      checks++;
      if (a_done !== 1'b0) begin errors++; $display("FAIL lsb_done_pulse: got %b want 0", a_done); end
   endtask

   task automatic test_msb_send();
      int exp_txd [10] = '{0, 1,0,0,0,0,0,0,1, 1};
      int shifts = 0;
      int txd_err = 0;
      int bad = 0;
      @(negedge clk);
      b_data  = 8'h81;
      b_valid = 1'b1;
      #1;
      checks++;
      if ({b_l, b_r, b_sr_d} !== {2'b11, 8'h81}) begin
         errors++; $display("FAIL msb_accept: l/r/d got %h want 381", {b_l, b_r, b_sr_d});
      end
      for (int cyc = 1; cyc <= 10; cyc++) begin
         @(negedge clk);
         b_valid = 1'b0;
         #1;
         if (b_txd !== 1'(exp_txd[cyc-1])) begin
            txd_err++;
            $display("FAIL msb_txd cycle %0d: got %b want %0d", cyc, b_txd, exp_txd[cyc-1]);
         end
         if (b_r && !b_l) shifts++;
         if (b_l || b_done) bad++;
      end
      checks++;
      if (txd_err != 0) errors++;
      checks++;
      if (shifts != 8) begin errors++; $display("FAIL msb_shift_count: got %0d want 8", shifts); end
      checks++;
      if (bad != 0) begin errors++; $display("FAIL msb_mode: got %0d bad cycles want 0", bad); end
      @(negedge clk); #1;
      checks++;
      if ({b_done, b_q} !== {1'b1, 8'hFF}) begin errors++; $display("FAIL msb_done_q: got %h want 1ff", {b_done, b_q}); end
   endtask

   task automatic test_back_to_back();
      int txd_err = 0;
      @(negedge clk);
      a_data  = 8'h3C;
      a_valid = 1'b1;
      #1;
      checks++;
      if ({a_l, a_r} !== 2'b11) begin errors++; $display("FAIL b2b_accept1: l/r got %b want 11", {a_l, a_r}); end
      for (int cyc = 1; cyc <= 20; cyc++) begin
         @(negedge clk);
         a_data = 8'hC3;
         #1;
         if (a_txd !== frame_bit(8'h3C, 1'b0, (cyc - 1) / 2)) txd_err++;
      end
      checks++;
      if (txd_err != 0) begin errors++; $display("FAIL b2b_frame1: got %0d wrong bits want 0", txd_err); end
      @(negedge clk); #1;
      checks++;
      if ({a_done, a_ready, a_l, a_r, a_sr_d} !== {4'b1111, 8'hC3}) begin
         errors++; $display("FAIL b2b_accept2: done/ready/l/r/d got %h want fc3", {a_done, a_ready, a_l, a_r, a_sr_d});
      end
      txd_err = 0;
      for (int cyc = 1; cyc <= 20; cyc++) begin
         @(negedge clk);
         a_valid = 1'b0;
         #1;
         if (a_txd !== frame_bit(8'hC3, 1'b0, (cyc - 1) / 2)) txd_err++;
      end
      checks++;
      if (txd_err != 0) begin errors++; $display("FAIL b2b_frame2: got %0d wrong bits want 0", txd_err); end
      @(negedge clk); #1;
      checks++;
      if ({a_done, a_q} !== {1'b1, 8'hFF}) begin errors++; $display("FAIL b2b_done2: got %h want 1ff", {a_done, a_q}); end
   endtask

   task automatic test_busy_ignore();
      int txd_err = 0;
      int busy_err = 0;
      @(negedge clk);
      a_data  = 8'hFF;
      a_valid = 1'b1;
      #1;
      for (int cyc = 1; cyc <= 20; cyc++) begin
         @(negedge clk);
         a_valid = (cyc == 6);
         a_data  = (cyc == 6) ? 8'h00 : 8'hFF;
         #1;
         if (cyc == 6) begin
            checks++;
            if ({a_ready, a_l && a_r} !== 2'b00) begin
               errors++; $display("FAIL busy_ignore_ready: ready/load got %b want 00", {a_ready, a_l && a_r});
            end
         end
         if (a_txd !== frame_bit(8'hFF, 1'b0, (cyc - 1) / 2)) txd_err++;
      end
      checks++;
      if (txd_err != 0) begin errors++; $display("FAIL busy_ignore_frame: got %0d wrong bits want 0", txd_err); end
      @(negedge clk); #1;
      checks++;
      if (a_done !== 1'b1) begin errors++; $display("FAIL busy_ignore_done: got %b want 1", a_done); end
      for (int cyc = 22; cyc <= 26; cyc++) begin
         @(negedge clk); #1;
         if (a_busy !== 1'b0 || a_txd !== 1'b1) busy_err++;
      end
      checks++;
      if (busy_err != 0) begin errors++; $display("FAIL busy_ignore_no_second: got %0d busy cycles want 0", busy_err); end
   endtask

   task automatic test_mid_reset();
      int txd_err = 0;
      int done_seen = 0;
      @(negedge clk);
      a_data  = 8'hA5;
      a_valid = 1'b1;
      #1;
      for (int cyc = 1; cyc <= 9; cyc++) begin
         @(negedge clk);
         a_valid = 1'b0;
         #1;
         if (a_txd !== frame_bit(8'hA5, 1'b0, (cyc - 1) / 2)) txd_err++;
      end
      checks++;
      if (txd_err != 0) begin errors++; $display("FAIL mid_reset_pre: got %0d wrong bits want 0", txd_err); end
      @(negedge clk);
      rst = 1'b1;
      #1;
      checks++;
      if ({a_txd, a_l, a_r, a_ready} !== 4'b0000) begin
         errors++; $display("FAIL mid_reset_hold: txd/l/r/ready got %b want 0000", {a_txd, a_l, a_r, a_ready});
      end
      @(negedge clk);
      rst = 1'b0;
      #1;
      checks++;
      if ({a_txd, a_busy, a_done, a_ready} !== 4'b1001) begin
         errors++; $display("FAIL mid_reset_idle: txd/busy/done/ready got %b want 1001", {a_txd, a_busy, a_done, a_ready});
      end
      checks++;
      if (a_q !== 8'hF4) begin errors++; $display("FAIL mid_reset_q_held: got %h want f4", a_q); end
      for (int cyc = 0; cyc < 15; cyc++) begin
         @(negedge clk); #1;
         if (a_done) done_seen++;
      end
      checks++;
      if (done_seen != 0) begin errors++; $display("FAIL mid_reset_no_done: got %0d pulses want 0", done_seen); end
      txd_err = 0;
      @(negedge clk);
      a_data  = 8'h55;
      a_valid = 1'b1;
      #1;
      for (int cyc = 1; cyc <= 20; cyc++) begin
         @(negedge clk);
         a_valid = 1'b0;
         #1;
         if (a_txd !== frame_bit(8'h55, 1'b0, (cyc - 1) / 2)) txd_err++;
      end
      checks++;
      if (txd_err != 0) begin errors++; $display("FAIL mid_reset_resend: got %0d wrong bits want 0", txd_err); end
      @(negedge clk); #1;
      checks++;
      if ({a_done, a_q} !== {1'b1, 8'hFF}) begin errors++; $display("FAIL mid_reset_resend_done: got %h want 1ff", {a_done, a_q}); end
   endtask

   initial begin
      test_reset();
      test_lsb_send();
      test_msb_send();
      test_back_to_back();
      test_busy_ignore();
      test_mid_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
